// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file write port among NUM_REQ
// requesters; the winner is registered onto the rf_* outputs one cycle later.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ZERO_REG_RO = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        rf_wr_en,
  output logic [ADDR_W-1:0]           rf_wr_reg,
  output logic [DATA_W-1:0]           rf_wr_data,
  output logic [2:0]                  grant_id,
  output logic [CNT_W-1:0]            stall_count,
  output logic [CNT_W-1:0]            drop_count
);

  logic [2:0]         r_rr_ptr;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_reg;
  logic [DATA_W-1:0]  r_wr_data;
  logic [2:0]         r_grant_id;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic [7:0]         w_valid8;
  logic [3:0]         w_idx;
  logic               w_found;
  logic [2:0]         w_gnt;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_ready;
  logic [ADDR_W-1:0]  w_sel_reg;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_zero_drop;
  logic               w_stall;
  logic [2:0]         w_next_ptr;

  // Zero-extend to 8 so a 3-bit index is always in range for any NUM_REQ.
  assign w_valid8 = 8'(req_valid);

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = 4'(r_rr_ptr) + 4'(k);
      if (w_idx >= 4'(NUM_REQ)) w_idx = w_idx - 4'(NUM_REQ);
      if (!w_found && w_valid8[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[2:0];
      end
    end
  end

  assign w_accept = rst_n && !hold && w_found;

  always_comb begin
    w_ready    = '0;
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == 3'(i)) begin
        w_ready[i] = w_accept;
        w_sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_zero_drop = (ZERO_REG_RO != 0) && (w_sel_reg == '0);
  assign w_stall     = |(req_valid & ~w_ready);
  assign w_next_ptr  = (w_gnt == 3'(NUM_REQ - 1)) ? '0 : w_gnt + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_wr_en     <= 1'b0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
      r_grant_id  <= '0;
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_wr_en <= w_accept && !w_zero_drop;
      if (w_accept) begin
        r_rr_ptr   <= w_next_ptr;
        r_wr_reg   <= w_sel_reg;
        r_wr_data  <= w_sel_data;
        r_grant_id <= w_gnt;
      end
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_accept && w_zero_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign req_ready   = w_ready;
  assign rf_wr_en    = r_wr_en;
  assign rf_wr_reg   = r_wr_reg;
  assign rf_wr_data  = r_wr_data;
  assign grant_id    = r_grant_id;
  assign stall_count = r_stall_cnt;
  assign drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, then random traffic
// checked against a queue/array-level reference model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic              clk;
  logic              rst_i;
  logic              hold_i;
  logic [NREQ-1:0]   valid_i;
  logic [NREQ*5-1:0] reg_i;
  logic [NREQ*32-1:0] data_i;
  logic [NREQ-1:0]   ready_o;
  logic              en_o;
  logic [4:0]        wreg_o;
  logic [31:0]       wdata_o;
  logic [2:0]        gid_o;
  logic [CW-1:0]     stall_o;
  logic [CW-1:0]     drop_o;

  regfile_write_arbiter #(
    .NUM_REQ(NREQ), .ADDR_W(5), .DATA_W(32), .ZERO_REG_RO(1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_i), .hold(hold_i),
    .req_valid(valid_i), .req_ready(ready_o),
    .req_reg(reg_i), .req_data(data_i),
    .rf_wr_en(en_o), .rf_wr_reg(wreg_o), .rf_wr_data(wdata_o),
    .grant_id(gid_o), .stall_count(stall_o), .drop_count(drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the arbiter outputs.
  logic [31:0] tb_rf [32];
  always @(posedge clk) if (en_o) tb_rf[wreg_o] <= wdata_o;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pointer and outputs as plain ints/arrays.
  int          m_ptr, m_win, m_acc, m_stall, m_drop;
  logic        m_en;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [2:0]  m_gid;
  logic [3:0]  m_ready;
  logic [31:0] m_rf [32];

  task automatic model_comb();
    m_win   = -1;
    m_ready = '0;
    if (rst_i && !hold_i)
      for (int k = 0; k < NREQ; k++)
        if (m_win < 0 && valid_i[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
    if (m_win >= 0) m_ready[m_win] = 1'b1;
  endtask

  task automatic model_seq();
    if (m_en) m_rf[m_reg] = m_data;
    if (!rst_i) begin
      m_ptr = 0; m_en = 1'b0; m_reg = '0; m_data = '0; m_gid = '0;
      m_stall = 0; m_drop = 0; m_acc = -1;
    end else begin
      m_acc = m_win;
      if ((valid_i & ~m_ready) != 0 && m_stall < (1 << CW) - 1) m_stall++;
      m_en = 1'b0;
      if (m_win >= 0) begin
        m_reg  = reg_i[m_win*5 +: 5];
        m_data = data_i[m_win*32 +: 32];
        m_gid  = 3'(m_win);
        m_ptr  = (m_win + 1) % NREQ;
        if (m_reg == 0) begin
          if (m_drop < (1 << CW) - 1) m_drop++;
        end else m_en = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        hold;
    logic [3:0]  valid;
    logic [4:0]  base_reg;
    logic [31:0] base_data;
    logic [3:0]  e_ready;
    logic        e_en;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [2:0]  e_gid;
    logic [3:0]  e_stall;
    logic [3:0]  e_drop;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic h, input logic [3:0] v,
                              input logic [4:0] br, input logic [31:0] bd,
                              input logic [3:0] er, input logic ee, input logic [4:0] eg,
                              input logic [31:0] ed, input logic [2:0] ei,
                              input logic [3:0] es, input logic [3:0] ez);
    vec_t t;
    t.rst_n = r; t.hold = h; t.valid = v; t.base_reg = br; t.base_data = bd;
    t.e_ready = er; t.e_en = ee; t.e_reg = eg; t.e_data = ed; t.e_gid = ei;
    t.e_stall = es; t.e_drop = ez;
    return t;
  endfunction

  // Requester i targets base_reg+i with data base_data+10*i.
  task automatic apply(input vec_t v);
    rst_i = v.rst_n; hold_i = v.hold; valid_i = v.valid;
    for (int i = 0; i < NREQ; i++) begin
      reg_i[i*5 +: 5]   = v.base_reg + 5'(i);
      data_i[i*32 +: 32] = v.base_data + 32'(10 * i);
    end
  endtask

  task automatic tick(input bit use_model, input vec_t v);
    #4;
    model_comb();
    chk("req_ready", 32'(ready_o), use_model ? 32'(m_ready) : 32'(v.e_ready));
    @(posedge clk);
    model_seq();
    #1;
    if (use_model) begin
      chk("rf_wr_en",    32'(en_o),    32'(m_en));
      chk("rf_wr_reg",   32'(wreg_o),  32'(m_reg));
      chk("rf_wr_data",  wdata_o,      m_data);
      chk("grant_id",    32'(gid_o),   32'(m_gid));
      chk("stall_count", 32'(stall_o), 32'(m_stall));
      chk("drop_count",  32'(drop_o),  32'(m_drop));
    end else begin
      chk("rf_wr_en",    32'(en_o),    32'(v.e_en));
      chk("rf_wr_reg",   32'(wreg_o),  32'(v.e_reg));
      chk("rf_wr_data",  wdata_o,      v.e_data);
      chk("grant_id",    32'(gid_o),   32'(v.e_gid));
      chk("stall_count", 32'(stall_o), 32'(v.e_stall));
      chk("drop_count",  32'(drop_o),  32'(v.e_drop));
    end
  endtask

  vec_t        tbl [24];
  vec_t        dummy;
  logic [3:0]  pend;
  logic [4:0]  p_reg [NREQ];
  logic [31:0] p_data [NREQ];

  initial begin
    for (int i = 0; i < 32; i++) begin tb_rf[i] = '0; m_rf[i] = '0; end
    m_ptr = 0; m_en = 1'b0; m_reg = '0; m_data = '0; m_gid = '0;
    m_stall = 0; m_drop = 0; m_acc = -1; m_win = -1; m_ready = '0;
    dummy = mk(1'b1, 1'b0, 4'h0, 5'd0, 32'd0, 4'h0, 1'b0, 5'd0, 32'd0, 3'd0, 4'd0, 4'd0);

    //            rst  hold valid   breg   bdata               rdy    en   reg    data           gid   stall drop
    tbl[0]  = mk(1'b0, 1'b0, 4'hF, 5'd1,  32'd0,              4'h0, 1'b0, 5'd0, 32'd0,         3'd0, 4'd0,  4'd0);
    tbl[1]  = mk(1'b0, 1'b0, 4'hF, 5'd1,  32'd0,              4'h0, 1'b0, 5'd0, 32'd0,         3'd0, 4'd0,  4'd0);
    tbl[2]  = mk(1'b1, 1'b0, 4'hF, 5'd1,  32'd0,              4'h1, 1'b1, 5'd1, 32'd0,         3'd0, 4'd1,  4'd0);
    tbl[3]  = mk(1'b1, 1'b0, 4'hF, 5'd1,  32'd0,              4'h2, 1'b1, 5'd2, 32'd10,        3'd1, 4'd2,  4'd0);
    tbl[4]  = mk(1'b1, 1'b0, 4'hF, 5'd1,  32'd0,              4'h4, 1'b1, 5'd3, 32'd20,        3'd2, 4'd3,  4'd0);
    tbl[5]  = mk(1'b1, 1'b0, 4'hF, 5'd1,  32'd0,              4'h8, 1'b1, 5'd4, 32'd30,        3'd3, 4'd4,  4'd0);
    tbl[6]  = mk(1'b1, 1'b0, 4'hF, 5'd1,  32'd0,              4'h1, 1'b1, 5'd1, 32'd0,         3'd0, 4'd5,  4'd0);
    tbl[7]  = mk(1'b1, 1'b0, 4'hF, 5'd1,  32'd0,              4'h2, 1'b1, 5'd2, 32'd10,        3'd1, 4'd6,  4'd0);
    tbl[8]  = mk(1'b1, 1'b0, 4'hF, 5'd1,  32'd0,              4'h4, 1'b1, 5'd3, 32'd20,        3'd2, 4'd7,  4'd0);
    tbl[9]  = mk(1'b1, 1'b0, 4'hF, 5'd1,  32'd0,              4'h8, 1'b1, 5'd4, 32'd30,        3'd3, 4'd8,  4'd0);
    tbl[10] = mk(1'b1, 1'b0, 4'h0, 5'd1,  32'd0,              4'h0, 1'b0, 5'd4, 32'd30,        3'd3, 4'd8,  4'd0);
    tbl[11] = mk(1'b1, 1'b0, 4'h4, 5'd5,  32'hDEADBEEF-32'd20, 4'h4, 1'b1, 5'd7, 32'hDEADBEEF, 3'd2, 4'd8,  4'd0);
    tbl[12] = mk(1'b1, 1'b0, 4'h0, 5'd5,  32'd0,              4'h0, 1'b0, 5'd7, 32'hDEADBEEF,  3'd2, 4'd8,  4'd0);
    tbl[13] = mk(1'b1, 1'b0, 4'h2, 5'd31, 32'd45,             4'h2, 1'b0, 5'd0, 32'd55,        3'd1, 4'd8,  4'd1);
    tbl[14] = mk(1'b1, 1'b0, 4'h0, 5'd31, 32'd45,             4'h0, 1'b0, 5'd0, 32'd55,        3'd1, 4'd8,  4'd1);
    tbl[15] = mk(1'b1, 1'b1, 4'h3, 5'd1,  32'd0,              4'h0, 1'b0, 5'd0, 32'd55,        3'd1, 4'd9,  4'd1);
    tbl[16] = mk(1'b1, 1'b1, 4'h3, 5'd1,  32'd0,              4'h0, 1'b0, 5'd0, 32'd55,        3'd1, 4'd10, 4'd1);
    tbl[17] = mk(1'b1, 1'b1, 4'h3, 5'd1,  32'd0,              4'h0, 1'b0, 5'd0, 32'd55,        3'd1, 4'd11, 4'd1);
    tbl[18] = mk(1'b1, 1'b0, 4'h3, 5'd1,  32'd0,              4'h1, 1'b1, 5'd1, 32'd0,         3'd0, 4'd12, 4'd1);
    tbl[19] = mk(1'b1, 1'b0, 4'h2, 5'd1,  32'd0,              4'h2, 1'b1, 5'd2, 32'd10,        3'd1, 4'd12, 4'd1);
    tbl[20] = mk(1'b1, 1'b0, 4'h0, 5'd1,  32'd0,              4'h0, 1'b0, 5'd2, 32'd10,        3'd1, 4'd12, 4'd1);
    tbl[21] = mk(1'b0, 1'b0, 4'h8, 5'd1,  32'h1000,           4'h0, 1'b0, 5'd0, 32'd0,         3'd0, 4'd0,  4'd0);
    tbl[22] = mk(1'b1, 1'b0, 4'h9, 5'd1,  32'd0,              4'h1, 1'b1, 5'd1, 32'd0,         3'd0, 4'd1,  4'd0);
    tbl[23] = mk(1'b1, 1'b0, 4'h0, 5'd1,  32'd0,              4'h0, 1'b0, 5'd1, 32'd0,         3'd0, 4'd1,  4'd0);

    for (int n = 0; n < 24; n++) begin
      apply(tbl[n]);
      tick(1'b0, tbl[n]);
      if (n == 12) chk("rf_reg7_after_write", tb_rf[7], 32'hDEADBEEF);
      if (n == 14) chk("rf_reg0_protected",   tb_rf[0], 32'd0);
      if (n == 23) chk("rf_reg4_no_write_across_reset", tb_rf[4], 32'd30);
    end

    pend = '0;
    for (int i = 0; i < NREQ; i++) begin p_reg[i] = '0; p_data[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      rst_i  = ($urandom_range(0, 59) != 0);
      hold_i = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          p_reg[i]  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
          p_data[i] = $urandom;
        end
        reg_i[i*5 +: 5]    = p_reg[i];
        data_i[i*32 +: 32] = p_data[i];
      end
      valid_i = pend;
      tick(1'b1, dummy);
      if (m_acc >= 0) pend[m_acc] = 1'b0;
    end

    rst_i = 1'b1; hold_i = 1'b0; valid_i = '0;
    tick(1'b1, dummy);
    tick(1'b1, dummy);
    for (int r = 0; r < 32; r++) chk("rf_contents", tb_rf[r], m_rf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
